fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequences the fetch-stage PC register against a multi-cycle instruction memory (req/gnt/rvalid).
//  Issues one fetch per PC and holds PCF (drives fetch_stage.stallF) until the instruction is accepted.
//  Discards responses made stale by a flush, buffers one response while decode is stalled,
//  and retries a fetch that is never answered.
// PARAMETERS
//  DPW        32   data/address width (from rv32i_pkg)
//  TIMEOUT    255  cycles without rvalid after gnt before a fetch is abandoned and retried
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    asynchronous, active-low reset
//  pcF            in   DPW  current PC (fetch_stage.PCF)
//  flush_i        in   1    redirect/flush from hazard unit (same cycle as fetch_stage.flushF)
//  stall_hz_i     in   1    downstream hazard stall: decode cannot accept an instruction
//  stallF_o       out  1    to fetch_stage.stallF; 1 = hold PCF
//  imem_req_o     out  1    fetch request
//  imem_addr_o    out  DPW  fetch address (= pcF while imem_req_o=1)
//  imem_gnt_i     in   1    request accepted this cycle
//  imem_rvalid_i  in   1    response valid (exactly one per grant, in order)
//  imem_rdata_i   in   32   response instruction
//  imem_err_i     in   1    response bus error, qualified by imem_rvalid_i
//  instrF_o       out  32   instruction to IF/ID register
//  instr_validF_o out  1    instrF_o valid this cycle
//  fetch_err_o    out  1    1-cycle pulse: bus error or timeout on a live fetch
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, hold buffer empty, timeout count 0, imem_req_o=0,
//   instr_validF_o=0, fetch_err_o=0, stallF_o=1, instrF_o=NOP (32'h0000_0013).
//  FSM states: IDLE, REQ, WAIT, DROP.
//   IDLE: after reset, go to REQ the next cycle.
//   REQ: imem_req_o=1, imem_addr_o=pcF. Requires hold buffer empty.
//    On gnt, go to WAIT. On flush without gnt, stay in REQ; the address follows the new pcF.
//    On flush with gnt in the same cycle, go to DROP.
//   WAIT: on rvalid without flush, deliver and go to REQ. On flush without rvalid, go to DROP.
//    On flush with rvalid in the same cycle, discard the response and go to REQ.
//   DROP: imem_req_o=0. On rvalid, discard the response and go to REQ.
//  Delivery: a live rvalid drives instr_validF_o=1 and instrF_o=imem_rdata_i combinationally.
//   If imem_err_i=1, instrF_o=NOP and fetch_err_o pulses.
//   - If stall_hz_i=0: stallF_o=0 that cycle, so PCF advances at the next edge.
//   - If stall_hz_i=1: capture the instruction in the hold buffer.
//     Stay in WAIT with hold full. No new request is issued while hold is full.
//  Hold full: instr_validF_o=1 and instrF_o=hold. The first cycle with stall_hz_i=0 gives
//   stallF_o=0; hold is emptied and the FSM goes to REQ. A flush empties hold and the FSM goes to REQ.
//  stallF_o = ~(delivering & ~stall_hz_i). It is 1 in every other cycle, including IDLE/REQ/DROP.
//   A flush overrides the stall in fetch_stage.
//  Timeout: the counter clears on gnt and counts in WAIT (hold empty) and in DROP.
//   When it reaches TIMEOUT: in WAIT, pulse fetch_err_o and go to REQ to retry the same pcF.
//   In DROP, go to REQ with no error.
//   A late rvalid after a timeout is ignored (DROP semantics). One outstanding request maximum.
//  Latency with a zero-wait memory (gnt with req, rvalid next cycle):
//   2 cycles per instruction, req in cycle n, delivery and PC update in cycle n+1.
//  rst_n asserted mid-fetch aborts everything immediately. Responses arriving after rst_n
//   deasserts are ignored, because the FSM starts from IDLE.
// STRUCTURE
//  rv32i_pkg additions: fetch_state_e {IDLE,REQ,WAIT,DROP}; NOP_INSTR=32'h0000_0013; FETCH_TO_W.
//  Sub-module: fetch_timeout_cnt (clear, enable, terminal-count flag, width $clog2(TIMEOUT+1)).
//  All remaining logic (FSM, hold buffer, output mux) stays in fetch_ctrl.
// TESTING
//  1. Reset release, zero-wait memory, rdata=32'h0050_0093.
//     -> req at cycle 1, instr_validF_o and stallF_o=0 at cycle 2, 2-cycle cadence thereafter.
//  2. gnt after 3 cycles, rvalid after 4 more -> imem_addr_o stable, stallF_o=1 throughout,
//     exactly one delivery.
//  3. flush_i during WAIT, stale rvalid returns 32'hDEAD_BEEF -> never on instr_validF_o.
//     The next req carries the new pcF.
//  4. stall_hz_i=1 when rvalid arrives (32'h0000_0113) -> held, instr_validF_o stays 1,
//     no req. Release stall -> stallF_o=0 once, then req.
//  5. No rvalid for TIMEOUT cycles -> fetch_err_o pulses once, req retried with the same pcF.
//     A late rvalid is ignored.
//  6. imem_err_i with rvalid -> instrF_o=32'h0000_0013, fetch_err_o=1. rst_n pulse in WAIT
//     -> all outputs return to reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch path.
// Fetch sequencing states and constants live here.
package rv32i_pkg;

  localparam int XLEN          = 32;
  localparam int FETCH_TIMEOUT = 255;
  localparam int FETCH_TO_W    = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Cycle counter for an outstanding fetch.
// Saturates at TIMEOUT and raises tc there.
module fetch_timeout_cnt #(
  parameter int TIMEOUT = 255,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer for a req/gnt/rvalid instruction memory.
// Holds PCF until decode accepts the fetched instruction.
module fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter int DPW     = XLEN,
  parameter int TIMEOUT = FETCH_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DPW-1:0] pcF,
  input  logic           flush_i,
  input  logic           stall_hz_i,
  output logic           stallF_o,
  output logic           imem_req_o,
  output logic [DPW-1:0] imem_addr_o,
  input  logic           imem_gnt_i,
  input  logic           imem_rvalid_i,
  input  logic [31:0]    imem_rdata_i,
  input  logic           imem_err_i,
  output logic [31:0]    instrF_o,
  output logic           instr_validF_o,
  output logic           fetch_err_o
);

  fetch_state_e state, state_d;

  logic        hold_full;
  logic [31:0] hold;
  logic        hold_set, hold_clr;
  logic        to_err, tc;
  logic        waiting, live_rv;
  logic        cnt_en, cnt_clr;
  logic [31:0] resp_data;

  assign waiting   = (state == WAIT) && !hold_full;
  assign live_rv   = waiting && imem_rvalid_i && !flush_i;
  assign resp_data = imem_err_i ? NOP_INSTR : imem_rdata_i;

  assign cnt_en  = waiting || (state == DROP);
  assign cnt_clr = (imem_req_o && imem_gnt_i) || !cnt_en;

  fetch_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_to (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_d    = state;
    hold_set   = 1'b0;
    hold_clr   = 1'b0;
    imem_req_o = 1'b0;
    to_err     = 1'b0;
    unique case (state)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) state_d = flush_i ? DROP : WAIT;
      end
      WAIT: begin
        if (hold_full) begin
          if (flush_i || !stall_hz_i) begin
            hold_clr = 1'b1;
            state_d  = REQ;
          end
        end else if (imem_rvalid_i) begin
          if (flush_i)         state_d  = REQ;
          else if (stall_hz_i) hold_set = 1'b1;
          else                 state_d  = REQ;
        end else if (flush_i) begin
          state_d = DROP;
        end else if (tc) begin
          to_err  = 1'b1;
          state_d = REQ;
        end
      end
      DROP: if (imem_rvalid_i || tc) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold      <= NOP_INSTR;
    end else begin
      state <= state_d;
      if (hold_set) begin
        hold_full <= 1'b1;
        hold      <= resp_data;
      end else if (hold_clr) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign imem_addr_o    = pcF;
  assign instr_validF_o = hold_full || live_rv;
  assign stallF_o       = !(instr_validF_o && !stall_hz_i);
  assign fetch_err_o    = (live_rv && imem_err_i) || to_err;

  always_comb begin
    instrF_o = NOP_INSTR;
    if (hold_full)    instrF_o = hold;
    else if (live_rv) instrF_o = resp_data;
  end

endmodule
